// File: rtl/hog_pkg.sv
// ----------------------------------------------------------------------------
// hog_pkg
// Shared definitions for the HOG front end.
//   feeder_state_e : pixel_feeder FSM states (FILL, RUN, FLUSH)
//   *_SLOT         : position of each neighbour field inside the packed
//                    {up, down, left, right} vector, counted in pixels
//   field_lsb()    : turns a slot and a pixel width into a bit offset, so
//                    UP_LSB = 3*PIX_W, DOWN_LSB = 2*PIX_W, LEFT_LSB = PIX_W,
//                    RIGHT_LSB = 0
// ----------------------------------------------------------------------------
package hog_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } feeder_state_e;

  localparam int UP_SLOT    = 3;
  localparam int DOWN_SLOT  = 2;
  localparam int LEFT_SLOT  = 1;
  localparam int RIGHT_SLOT = 0;

  function automatic int field_lsb(input int slot, input int pix_w);
    return slot * pix_w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// ----------------------------------------------------------------------------
// line_buffer
// One image row held in an IMG_W x PIX_W register array. One synchronous
// write port and three combinational read ports at columns c-1, c and c+1
// around a shared column address. Reads return the value before any write
// on the same edge. Contents are deliberately not reset.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_addr   in   column address (write column and read centre)
//   i_wdata  in   pixel to write
//   o_rd_m1  out  pixel at column c-1 (clamped to c at column 0)
//   o_rd_c   out  pixel at column c
//   o_rd_p1  out  pixel at column c+1 (clamped to c at the last column)
// ----------------------------------------------------------------------------
module line_buffer #(
  parameter  int PIX_W = 8,
  parameter  int IMG_W = 64,
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rd_m1,
  output logic [PIX_W-1:0] o_rd_c,
  output logic [PIX_W-1:0] o_rd_p1
);

  localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [AW-1:0] A_LAST = AW'(IMG_W - 1);

  logic [PIX_W-1:0] r_mem [IMG_W];
  logic [AW-1:0]    w_addr_m1;
  logic [AW-1:0]    w_addr_p1;

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Neighbour addresses stay inside the row; the caller substitutes borders.
  always_comb begin
    if (i_addr == A_ZERO) begin
      w_addr_m1 = i_addr;
    end else begin
      w_addr_m1 = i_addr - A_ONE;
    end
    if (i_addr == A_LAST) begin
      w_addr_p1 = i_addr;
    end else begin
      w_addr_p1 = i_addr + A_ONE;
    end
  end

  assign o_rd_m1 = r_mem[w_addr_m1];
  assign o_rd_c  = r_mem[i_addr];
  assign o_rd_p1 = r_mem[w_addr_p1];

endmodule

// File: rtl/pixel_feeder.sv
// ----------------------------------------------------------------------------
// pixel_feeder
// Turns a row-major pixel stream into one packed {up, down, left, right}
// neighbour vector per pixel of an IMG_W x IMG_H frame, in raster order.
// Two line buffers swap OLD/CUR roles at each row end. Row 0 is only
// buffered (FILL); each later accepted pixel completes the vector of the
// pixel directly above it (RUN); the last row is replayed from the buffers
// (FLUSH).
// Build option:
//   PIXEL_FEEDER_ZERO_PAD_EN  defined -> out-of-frame neighbours are 0;
//                             undefined -> they replicate the centre pixel.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   pix_valid  in   upstream pixel valid
//   pix        in   upstream pixel
//   pix_ready  out  upstream accept (request and not flushing)
//   request    in   downstream throttle; nothing moves while low
//   ready      out  registered o_data valid strobe
//   o_data     out  registered {up, down, left, right}, up in the MSBs
// ----------------------------------------------------------------------------
module pixel_feeder
  import hog_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 128,
  localparam int OUT_W = 4 * PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix,
  output logic             pix_ready,
  input  logic             request,
  output logic             ready,
  output logic [OUT_W-1:0] o_data
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam int UP_LSB    = field_lsb(UP_SLOT, PIX_W);
  localparam int DOWN_LSB  = field_lsb(DOWN_SLOT, PIX_W);
  localparam int LEFT_LSB  = field_lsb(LEFT_SLOT, PIX_W);
  localparam int RIGHT_LSB = field_lsb(RIGHT_SLOT, PIX_W);

  feeder_state_e    r_state;
  feeder_state_e    w_next_state;
  logic [RW-1:0]    r_row;       // row of the next input pixel
  logic [CW-1:0]    r_col;       // column of the next input pixel
  logic [CW-1:0]    r_fcol;      // column of the next flush output
  logic             r_sel;       // 0: buffer 0 is CUR, 1: buffer 1 is CUR
  logic             r_ready;
  logic [OUT_W-1:0] r_data;

  logic             w_accept;
  logic             w_emit;
  logic             w_cur_we;
  logic             w_old_we;
  logic             w_row_end;
  logic [CW-1:0]    w_col;
  logic             w_we0;
  logic             w_we1;
  logic [PIX_W-1:0] w_b0_m1, w_b0_c, w_b0_p1;
  logic [PIX_W-1:0] w_b1_m1, w_b1_c, w_b1_p1;
  logic [PIX_W-1:0] w_cur_m1, w_cur_c, w_cur_p1, w_old_c;
  logic [PIX_W-1:0] w_border;
  logic [OUT_W-1:0] w_vec;

  assign w_row_end = (r_col == COL_LAST);
  assign w_col     = (r_state == ST_FLUSH) ? r_fcol : r_col;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_accept && w_row_end) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_RUN: begin
        if (w_accept && w_row_end && (r_row == ROW_LAST)) begin
          w_next_state = ST_FLUSH;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (request && (r_fcol == COL_LAST)) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_FLUSH;
        end
      end
      default: begin
        w_next_state = ST_FILL;
      end
    endcase
  end

  // FSM outputs: upstream handshake, emission and buffer write roles.
  always_comb begin
    pix_ready = 1'b0;
    w_accept  = 1'b0;
    w_emit    = 1'b0;
    w_cur_we  = 1'b0;
    w_old_we  = 1'b0;
    case (r_state)
      ST_FILL: begin
        pix_ready = request;
        w_accept  = request & pix_valid;
        w_cur_we  = w_accept;
      end
      ST_RUN: begin
        pix_ready = request;
        w_accept  = request & pix_valid;
        w_emit    = w_accept;
        w_old_we  = w_accept;
      end
      ST_FLUSH: begin
        w_emit = request;
      end
      default: begin
        pix_ready = 1'b0;
      end
    endcase
  end

  // Position counters and ping-pong select; all hold while request is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= ROW_ZERO;
      r_col  <= COL_ZERO;
      r_fcol <= COL_ZERO;
      r_sel  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_row_end) begin
          r_col <= COL_ZERO;
          r_row <= (r_row == ROW_LAST) ? ROW_ZERO : (r_row + ROW_ONE);
          // Row 0 lands in CUR with no swap; later rows written into OLD
          // become the new CUR.
          if (r_state == ST_RUN) begin
            r_sel <= ~r_sel;
          end
        end else begin
          r_col <= r_col + COL_ONE;
        end
      end
      if ((r_state == ST_FLUSH) && request) begin
        r_fcol <= (r_fcol == COL_LAST) ? COL_ZERO : (r_fcol + COL_ONE);
      end
    end
  end

  assign w_we0 = r_sel ? w_old_we : w_cur_we;
  assign w_we1 = r_sel ? w_cur_we : w_old_we;

  line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_buf0 (
    .clk(clk), .i_we(w_we0), .i_addr(w_col), .i_wdata(pix),
    .o_rd_m1(w_b0_m1), .o_rd_c(w_b0_c), .o_rd_p1(w_b0_p1)
  );

  line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_buf1 (
    .clk(clk), .i_we(w_we1), .i_addr(w_col), .i_wdata(pix),
    .o_rd_m1(w_b1_m1), .o_rd_c(w_b1_c), .o_rd_p1(w_b1_p1)
  );

  assign w_cur_m1 = r_sel ? w_b1_m1 : w_b0_m1;
  assign w_cur_c  = r_sel ? w_b1_c  : w_b0_c;
  assign w_cur_p1 = r_sel ? w_b1_p1 : w_b0_p1;
  assign w_old_c  = r_sel ? w_b0_c  : w_b1_c;

`ifdef PIXEL_FEEDER_ZERO_PAD_EN
  assign w_border = {PIX_W{1'b0}};
`else
  assign w_border = w_cur_c;
`endif

  // Neighbour vector for the centre pixel CUR[col] with frame borders.
  // Centre row 0 is current while the input is on row 1; down only leaves
  // the frame during FLUSH, which replays the last row.
  always_comb begin
    w_vec = {OUT_W{1'b0}};
    if ((r_state == ST_RUN) && (r_row == ROW_ONE)) begin
      w_vec[UP_LSB +: PIX_W] = w_border;
    end else begin
      w_vec[UP_LSB +: PIX_W] = w_old_c;
    end
    if (r_state == ST_FLUSH) begin
      w_vec[DOWN_LSB +: PIX_W] = w_border;
    end else begin
      w_vec[DOWN_LSB +: PIX_W] = pix;
    end
    if (w_col == COL_ZERO) begin
      w_vec[LEFT_LSB +: PIX_W] = w_border;
    end else begin
      w_vec[LEFT_LSB +: PIX_W] = w_cur_m1;
    end
    if (w_col == COL_LAST) begin
      w_vec[RIGHT_LSB +: PIX_W] = w_border;
    end else begin
      w_vec[RIGHT_LSB +: PIX_W] = w_cur_p1;
    end
  end

  // Registered output: ready strobes for one cycle per emitted vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_data  <= {OUT_W{1'b0}};
    end else begin
      r_ready <= w_emit;
      if (w_emit) begin
        r_data <= w_vec;
      end
    end
  end

  assign ready  = r_ready;
  assign o_data = r_data;

endmodule

// File: tb/tb_pixel_feeder.sv
// ----------------------------------------------------------------------------
// tb_pixel_feeder
// Self-checking bench for pixel_feeder with a 4x3 frame, pixel(r,c)=16*r+c.
// Each accepted pixel (and each flush cycle) pushes the independently
// computed neighbour vector onto a scoreboard queue; the vector must appear
// on o_data with ready exactly one cycle later. A table of hand-computed
// vectors is checked against the captured frame.
// ----------------------------------------------------------------------------
module tb_pixel_feeder;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix;
  logic        pix_ready;
  logic        request;
  logic        ready;
  logic [31:0] o_data;

  int          checks = 0;
  int          errors = 0;

  // Bench-side model of the frame position.
  int          m_idx;
  logic        m_flush;
  int          m_fidx;
  logic        m_done;
  int          n_vec;
  logic [31:0] exp_q[$];
  logic [31:0] cap [NPIX];

  typedef struct {
    int          r;
    int          c;
    logic [31:0] exp;
  } spot_t;
  spot_t spots [4];

  pixel_feeder #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix(pix),
    .pix_ready(pix_ready), .request(request), .ready(ready), .o_data(o_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pel(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  function automatic logic [31:0] exp_vec(input int r, input int c);
    logic [7:0] ctr, bd, u, d, l, rt;
    ctr = pel(r, c);
`ifdef PIXEL_FEEDER_ZERO_PAD_EN
    bd = 8'h00;
`else
    bd = ctr;
`endif
    u  = (r == 0)     ? bd : pel(r - 1, c);
    d  = (r == H - 1) ? bd : pel(r + 1, c);
    l  = (c == 0)     ? bd : pel(r, c - 1);
    rt = (c == W - 1) ? bd : pel(r, c + 1);
    return {u, d, l, rt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge+1, predict, then check outputs at the next negedge.
  task automatic tick(input logic req, input logic pv);
    logic        exp_prdy;
    logic        exp_rdy;
    logic [31:0] e;
    request   = req;
    pix_valid = pv;
    pix       = pel(m_idx / W, m_idx % W);
    #1;
    exp_prdy = req & ~m_flush;
    chk("pix_ready", 32'(pix_ready), 32'(exp_prdy));
    if (pv && exp_prdy) begin
      if (m_idx >= W) exp_q.push_back(exp_vec((m_idx - W) / W, (m_idx - W) % W));
      m_idx++;
      if (m_idx == NPIX) begin
        m_flush = 1'b1;
        m_fidx  = 0;
      end
    end else if (m_flush && req) begin
      exp_q.push_back(exp_vec(H - 1, m_fidx));
      m_fidx++;
      if (m_fidx == W) begin
        m_flush = 1'b0;
        m_idx   = 0;
        m_done  = 1'b1;
      end
    end
    @(negedge clk);
    exp_rdy = (exp_q.size() != 0);
    chk("ready", 32'(ready), 32'(exp_rdy));
    if (ready) begin
      if (exp_rdy) begin
        e = exp_q.pop_front();
        chk($sformatf("o_data_vec%0d", n_vec), o_data, e);
      end
      if (n_vec < NPIX) cap[n_vec] = o_data;
      n_vec++;
    end
    exp_q.delete();
    #1;
  endtask

  // Stream one frame; optional request drop (by cycle) and flush-start stall.
  task automatic run_frame(input int drop_at, input int drop_len, input int flush_stall);
    int   cyc;
    int   stall;
    logic req;
    cyc    = 0;
    stall  = flush_stall;
    m_done = 1'b0;
    n_vec  = 0;
    while (!m_done && cyc < 200) begin
      req = 1'b1;
      if (cyc >= drop_at && cyc < drop_at + drop_len) req = 1'b0;
      if (m_flush && m_fidx == 0 && stall > 0) begin
        req = 1'b0;
        stall--;
      end
      tick(req, 1'b1);
      cyc++;
    end
    if (!m_done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d cycles, required completion", cyc);
    end
    chk("vec_count", 32'(n_vec), 32'(NPIX));
  endtask

  task automatic check_spots();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("spot_r%0d_c%0d", spots[i].r, spots[i].c),
          cap[spots[i].r * W + spots[i].c], spots[i].exp);
    end
  endtask

  initial begin
    spots[0] = '{r: 0, c: 0, exp: 32'h00100001};
    spots[1] = '{r: 1, c: 2, exp: 32'h02221113};
`ifdef PIXEL_FEEDER_ZERO_PAD_EN
    spots[2] = '{r: 2, c: 3, exp: 32'h13002200};
    spots[3] = '{r: 0, c: 3, exp: 32'h00130200};
`else
    spots[2] = '{r: 2, c: 3, exp: 32'h13232223};
    spots[3] = '{r: 0, c: 3, exp: 32'h03130203};
`endif
    m_idx = 0; m_flush = 1'b0; m_fidx = 0; m_done = 1'b0; n_vec = 0;

    // Reset state.
    rst = 1'b1; request = 1'b0; pix_valid = 1'b0; pix = 8'h00;
    #1 rst = 1'b0;
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_odata", o_data, 32'd0);
    chk("reset_pix_ready_lo", 32'(pix_ready), 32'd0);
    request = 1'b1;
    #1;
    chk("reset_pix_ready_hi", 32'(pix_ready), 32'd1);
    request = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;

    // Frame 1: request drop of 3 cycles at pixel (1,2).
    run_frame(6, 3, 0);
    check_spots();

    // Frame 2 back to back: request drops as the last pixel is accepted.
    run_frame(-1, 0, 2);
    check_spots();

    // Partial frame, then reset during row 1.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_odata", o_data, 32'd0);
    request = 1'b1; pix_valid = 1'b1;
    #1;
    chk("midrst_pix_ready", 32'(pix_ready), 32'd1);
    request = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    m_idx = 0; m_flush = 1'b0; m_fidx = 0;

    // Fresh frame after reset.
    run_frame(-1, 0, 0);
    check_spots();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
